data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache between the CPU's data-memory port and the 32-bit-block data memory. It serves byte reads and writes from the CPU (8-bit address, 8-bit data) from 8 lines of 4 bytes each. On a miss it stalls the CPU via BUSYWAIT while it writes back a dirty victim and fetches the block. Read and write hits complete with no stall.

## Interface
- Parameters: none; geometry is fixed by package constants (8 lines, 4-byte blocks).
- CLK  in  1  clock, all state updates on posedge
- RESET  in  1  synchronous, active-high
- READ  in  1  CPU byte-read request
- WRITE  in  1  CPU byte-write request
- ADDRESS  in  8  CPU byte address: tag [7:5], index [4:2], offset [1:0]
- WRITEDATA  in  8  CPU store data
- READDATA  out  8  load data, combinational from the indexed line
- BUSYWAIT  out  1  CPU stall
- MEM_READ  out  1  block-read request to data memory
- MEM_WRITE  out  1  block-write request to data memory
- MEM_ADDRESS  out  6  block address {tag,index}
- MEM_WRITEDATA  out  32  victim block, byte 0 in [7:0]
- MEM_READDATA  in  32  fetched block
- MEM_BUSYWAIT  in  1  memory busy; rises combinationally with MEM_READ/MEM_WRITE and stays high until data is valid or the write is done

## Operation
- Per line: valid, dirty, 3-bit tag, 32-bit data. hit = valid[index] & (tag[index]==ADDRESS[7:5]).
- Requests: req = READ|WRITE. READ and WRITE together is illegal; READ takes priority and WRITE is ignored.
- Read hit: READDATA = byte ADDRESS[1:0] of the line. BUSYWAIT=0.
- Write hit: byte written at posedge; dirty←1. BUSYWAIT=0.
- FSM states:
  - IDLE: on req & miss, go to WRITEBACK if dirty[index], else FETCH.
  - WRITEBACK: MEM_WRITE=1; MEM_ADDRESS={victim tag,index}; MEM_WRITEDATA=line data. When !MEM_BUSYWAIT, go to FETCH.
  - FETCH: MEM_READ=1; MEM_ADDRESS=ADDRESS[7:2]. When !MEM_BUSYWAIT, go to FILL.
  - FILL: line←MEM_READDATA; tag←ADDRESS[7:5]; valid←1; dirty←0. Go to IDLE.
- BUSYWAIT = (state≠IDLE) | (req & !hit). After FILL, the request is re-evaluated in IDLE as a hit and completes there; a write also sets dirty then.
- MEM_READ and MEM_WRITE are never high together. Both are 0 in IDLE and FILL.
- READDATA is don't-care when READ=0.

## Timing
- Reset, synchronous: state←IDLE; all valid and dirty←0. MEM_READ=MEM_WRITE=0 and BUSYWAIT=0 from the next edge.
- RESET mid-WRITEBACK or mid-FETCH abandons the memory transaction. Dirty data is lost; memory must tolerate a dropped request.
- Hit latency: 0 stall cycles; write commits on the same edge the CPU advances its PC.
- Clean miss: 1 IDLE detect cycle, then FETCH for (memory latency L+1) cycles, then 1 FILL cycle, then the completing IDLE cycle.
- Dirty miss: adds WRITEBACK for (L+1) cycles.
- BUSYWAIT rises in the same cycle the miss request appears. It falls in the IDLE cycle after FILL.
- Outputs are driven combinationally from state and registered arrays; no input-to-output path other than hit/BUSYWAIT/READDATA.

## Configuration
- DCACHE_STATS_EN defined: adds outputs HIT_COUNT (16 bit) and MISS_COUNT (16 bit), saturating at 0xFFFF and cleared by RESET.
  - HIT_COUNT increments once per request completed in IDLE without an intervening miss.
  - MISS_COUNT increments on each IDLE→WRITEBACK/FETCH transition.
- DCACHE_STATS_EN undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package dcache_pkg:
  - constants TAG_W=3, INDEX_W=3, OFFSET_W=2, NUM_LINES=8, BLOCK_W=32
  - state enum {IDLE, WRITEBACK, FETCH, FILL}
- Sub-module dcache_line_array holds the valid/dirty/tag/data arrays.
  - Reads are combinational.
  - Writes are on posedge, either a byte write or a full-line fill.
  - Reset clears valid and dirty.
- data_cache holds the FSM, hit logic and memory-side muxing.

## Test plan
- Cold read miss: after reset, READ ADDRESS=0x25 -> BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=0x09. Memory returns 0xDDCCBBAA after 5 cycles -> READDATA=0xBB, BUSYWAIT falls the cycle after FILL.
- Read hit: then READ 0x24 -> READDATA=0xAA, BUSYWAIT=0, MEM_READ stays 0.
- Write hit: WRITE 0x26 with data 0x5A -> no memory access. A following READ 0x26 -> 0x5A, and the line is dirty.
- Dirty eviction: READ 0x45 -> MEM_WRITE=1, MEM_ADDRESS=0x09, MEM_WRITEDATA=0xDD5ABBAA. Then MEM_READ=1 with MEM_ADDRESS=0x11; never both high.
- Reset mid-fetch: RESET during FETCH -> next edge MEM_READ=0 and BUSYWAIT=0. A following READ 0x25 misses again.
- DCACHE_STATS_EN: run the above sequence -> HIT_COUNT=3, MISS_COUNT=2. Build without the macro compiles without the ports.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared geometry constants, controller state type and byte-select helper for the data cache.
package dcache_pkg;

  localparam int unsigned TAG_W     = 3;
  localparam int unsigned INDEX_W   = 3;
  localparam int unsigned OFFSET_W  = 2;
  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned BLOCK_W   = 32;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_e;

  // Byte 0 of a block lives in bits [7:0].
  function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0]  blk,
                                            input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage for the direct-mapped cache; combinational read of the indexed line.
module dcache_line_array
  import dcache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INDEX_W-1:0]  index,
  output logic                valid,
  output logic                dirty,
  output logic [TAG_W-1:0]    tag,
  output logic [BLOCK_W-1:0]  data,
  input  logic                byte_we,
  input  logic [OFFSET_W-1:0] byte_offset,
  input  logic [7:0]          byte_data,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];

  assign valid = valid_q[index];
  assign dirty = dirty_q[index];
  assign tag   = tag_q[index];
  assign data  = data_q[index];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (byte_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  // Tags and data need no reset: they are only observed through a valid line.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (fill_we) begin
        tag_q[index]  <= fill_tag;
        data_q[index] <= fill_data;
      end else if (byte_we) begin
        data_q[index][{byte_offset, 3'b000} +: 8] <= byte_data;
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate byte cache (8 lines x 4 bytes).
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module data_cache
  import dcache_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                READ,
  input  logic                WRITE,
  input  logic [7:0]          ADDRESS,
  input  logic [7:0]          WRITEDATA,
  output logic [7:0]          READDATA,
  output logic                BUSYWAIT,
  output logic                MEM_READ,
  output logic                MEM_WRITE,
  output logic [5:0]          MEM_ADDRESS,
  output logic [BLOCK_W-1:0]  MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]  MEM_READDATA,
  input  logic                MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]         HIT_COUNT,
  output logic [15:0]         MISS_COUNT
`endif
);

  state_e state_q;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;
  logic                line_valid, line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                req, hit, idle, byte_we, fill_we;

  assign addr_tag    = ADDRESS[7:5];
  assign addr_index  = ADDRESS[4:2];
  assign addr_offset = ADDRESS[1:0];

  assign req     = READ | WRITE;
  assign hit     = line_valid & (line_tag == addr_tag);
  assign idle    = (state_q == IDLE);
  // READ wins when both are asserted, so a simultaneous WRITE is dropped.
  assign byte_we = idle & WRITE & ~READ & hit;
  assign fill_we = (state_q == FILL);

  dcache_line_array u_lines (
    .CLK         (CLK),
    .RESET       (RESET),
    .index       (addr_index),
    .valid       (line_valid),
    .dirty       (line_dirty),
    .tag         (line_tag),
    .data        (line_data),
    .byte_we     (byte_we),
    .byte_offset (addr_offset),
    .byte_data   (WRITEDATA),
    .fill_we     (fill_we),
    .fill_tag    (addr_tag),
    .fill_data   (MEM_READDATA)
  );

  assign READDATA      = block_byte(line_data, addr_offset);
  assign BUSYWAIT      = ~idle | (req & ~hit);
  assign MEM_READ      = (state_q == FETCH);
  assign MEM_WRITE     = (state_q == WRITEBACK);
  assign MEM_ADDRESS   = MEM_WRITE ? {line_tag, addr_index} : ADDRESS[7:2];
  assign MEM_WRITEDATA = line_data;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:      if (req && !hit) state_q <= line_dirty ? WRITEBACK : FETCH;
        WRITEBACK: if (!MEM_BUSYWAIT) state_q <= FETCH;
        FETCH:     if (!MEM_BUSYWAIT) state_q <= FILL;
        FILL:      state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic        refill_q;

  // The IDLE cycle right after FILL completes a request that already counted as a miss.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      refill_q   <= 1'b0;
    end else begin
      refill_q <= fill_we;
      if (idle && req && hit && !refill_q && hit_cnt_q != 16'hFFFF) begin
        hit_cnt_q <= hit_cnt_q + 16'd1;
      end
      if (idle && req && !hit && miss_cnt_q != 16'hFFFF) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: flat 256-byte reference view plus a latency-5 block memory.
module tb_data_cache;

  localparam int MemLat = 5;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        READ = 1'b0, WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00, WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
`ifdef DCACHE_STATS_EN
  logic [15:0] HIT_COUNT, MISS_COUNT;
`endif

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT     (HIT_COUNT),
    .MISS_COUNT    (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Block memory: busy rises with the request and drops after MemLat cycles.
  logic [31:0] mem [64];
  logic        mem_init_done = 1'b0;
  logic        mem_ready = 1'b0;
  int          mem_cnt = 0;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) & ~mem_ready;
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= {8'(i), 8'(i), 8'(i), 8'(i)};
      mem[9]        <= 32'hDDCCBBAA;
      mem[17]       <= 32'h44332211;
      mem_init_done <= 1'b1;
    end
    if (MEM_READ || MEM_WRITE) begin
      if (!mem_ready) begin
        if (mem_cnt == MemLat - 1) mem_ready <= 1'b1;
        else mem_cnt <= mem_cnt + 1;
      end else begin
        mem_ready <= 1'b0;
        mem_cnt   <= 0;
        if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      end
    end else begin
      mem_ready <= 1'b0;
      mem_cnt   <= 0;
    end
  end

  // Reference: the cache must look like a flat byte memory; reset reverts it to backing store.
  logic [7:0]  arch [256];
  int          n_rd = 0, n_wr = 0;
  logic [5:0]  last_rd_addr = '0, last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always @(negedge CLK) begin
    if (RESET) begin
      for (int w = 0; w < 64; w++)
        for (int b = 0; b < 4; b++) arch[w*4+b] = mem[w][b*8 +: 8];
    end else begin
      check("mem_rd_wr_exclusive", {31'd0, MEM_READ & MEM_WRITE}, 32'd0);
      if (READ && !BUSYWAIT) check("readdata_vs_model", {24'd0, READDATA}, {24'd0, arch[ADDRESS]});
      if (MEM_WRITE) begin
        check("victim_vs_model", MEM_WRITEDATA,
              {arch[MEM_ADDRESS*4+3], arch[MEM_ADDRESS*4+2],
               arch[MEM_ADDRESS*4+1], arch[MEM_ADDRESS*4]});
        n_wr++;
        last_wr_addr = MEM_ADDRESS;
        last_wr_data = MEM_WRITEDATA;
      end
      if (MEM_READ) begin
        n_rd++;
        last_rd_addr = MEM_ADDRESS;
      end
      if (WRITE && !READ && !BUSYWAIT) arch[ADDRESS] = WRITEDATA;
    end
  end

  task automatic cpu_req(input logic rd, input logic wr, input logic [7:0] addr,
                         input logic [7:0] wdata, output int stalls, output logic [7:0] rdata);
    bit done = 0;
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wdata;
    stalls = 0;
    rdata  = 8'h00;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) begin
        done  = 1;
        rdata = READDATA;
        break;
      end
      stalls++;
    end
    if (!done) check("request_timeout", 32'd0, 32'd1);
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  int         st, rd0, wr0;
  logic [7:0] rdv;

  initial begin
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("reset_mem_req", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);

    // Cold read miss: IDLE + FETCH(6) + FILL stall cycles.
    rd0 = n_rd; wr0 = n_wr;
    cpu_req(1'b1, 1'b0, 8'h25, 8'h00, st, rdv);
    check("cold_miss_data", {24'd0, rdv}, 32'h0000_00BB);
    check("cold_miss_stalls", st, 32'd8);
    check("cold_miss_fetch_addr", {26'd0, last_rd_addr}, 32'h09);
    check("cold_miss_no_wb", n_wr - wr0, 32'd0);
    check("cold_miss_fetch_cycles", n_rd - rd0, 32'd6);

    rd0 = n_rd;
    cpu_req(1'b1, 1'b0, 8'h24, 8'h00, st, rdv);
    check("read_hit_data", {24'd0, rdv}, 32'h0000_00AA);
    check("read_hit_stalls", st, 32'd0);

    cpu_req(1'b0, 1'b1, 8'h26, 8'h5A, st, rdv);
    check("write_hit_stalls", st, 32'd0);
    cpu_req(1'b1, 1'b0, 8'h26, 8'h00, st, rdv);
    check("read_after_write", {24'd0, rdv}, 32'h0000_005A);
    check("hits_no_mem", n_rd - rd0, 32'd0);

    // Dirty eviction of line 1 by tag 2.
    rd0 = n_rd; wr0 = n_wr;
    cpu_req(1'b1, 1'b0, 8'h45, 8'h00, st, rdv);
    check("evict_stalls", st, 32'd14);
    check("evict_wb_addr", {26'd0, last_wr_addr}, 32'h09);
    check("evict_wb_data", last_wr_data, 32'hDD5ABBAA);
    check("evict_fetch_addr", {26'd0, last_rd_addr}, 32'h11);
    check("evict_data", {24'd0, rdv}, 32'h0000_0022);
    check("evict_mem_updated", mem[9], 32'hDD5ABBAA);
`ifdef DCACHE_STATS_EN
    check("stats_hits", {16'd0, HIT_COUNT}, 32'd3);
    check("stats_misses", {16'd0, MISS_COUNT}, 32'd2);
`endif

    // Write-allocate miss, then read back.
    cpu_req(1'b0, 1'b1, 8'h81, 8'h77, st, rdv);
    check("write_miss_stalls", st, 32'd8);
    cpu_req(1'b1, 1'b0, 8'h81, 8'h00, st, rdv);
    check("write_miss_readback", {24'd0, rdv}, 32'h0000_0077);

    // Reset while fetching abandons the transaction.
    @(posedge CLK); #1;
    READ = 1'b1; ADDRESS = 8'h25;
    @(negedge CLK);
    check("rst_fetch_busy", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK);
    @(negedge CLK);
    check("rst_fetch_in_fetch", {31'd0, MEM_READ}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1; READ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_fetch_mem_read", {31'd0, MEM_READ}, 32'd0);
    check("rst_fetch_busywait", {31'd0, BUSYWAIT}, 32'd0);
`ifdef DCACHE_STATS_EN
    check("stats_cleared", {HIT_COUNT, MISS_COUNT}, 32'd0);
`endif
    cpu_req(1'b1, 1'b0, 8'h25, 8'h00, st, rdv);
    check("post_reset_miss_stalls", st, 32'd8);
    check("post_reset_data", {24'd0, rdv}, 32'h0000_00BB);

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
